// File: rtl/tdcchan_pkg.sv
// Shared widths and result record layouts for the single-channel TDC.
package tdcchan_pkg;

   localparam int FINE_W  = 6;
   localparam int WIDTH_W = 6;
   localparam int BC_W    = 7;

   typedef struct packed {
      logic [BC_W-1:0]   bc;
      logic [FINE_W-1:0] fine;
   } tdc_raw_t;

   typedef struct packed {
      logic [WIDTH_W-1:0] width;
      logic [FINE_W-1:0]  fine;
   } tdc_out_t;

endpackage

// File: rtl/tdcchan_sync.sv
// Pin synchronizer with rise/fall pulse generation. A pin that is already high
// when reset releases yields no rise until the pin has been seen low.
module tdcchan_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic [SYNC_STAGES-1:0] fill;
   logic                   s_d;
   logic                   armed;

   // fill marks when the chain holds real pin samples rather than reset zeros
   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= '0;
         fill  <= '0;
         s_d   <= 1'b0;
         armed <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], pin};
         fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
         s_d   <= chain[SYNC_STAGES-1];
         armed <= armed | (fill[SYNC_STAGES-1] & ~chain[SYNC_STAGES-1]);
      end
   end

   assign s    = chain[SYNC_STAGES-1];
   assign rise = s & ~s_d & armed;
   assign fall = ~s & s_d;

endmodule

// File: rtl/tdcchan.sv
// Single-channel TDC: time-stamps synced hit rises against bc_time plus a sub-BC
// fine counter and reports calibrated width/fine. Option: TDCCHAN_GLITCH_FILTER_EN.
module tdcchan #(
   parameter int SYNC_STAGES = 2,
   parameter int FINE_W      = 6,
   parameter int WIDTH_W     = 6,
   parameter int MIN_WIDTH   = 2
) (
   input  logic                      clk600,
   input  logic                      reset,
   input  logic                      pin_in,
   output logic                      pin_out,
   input  logic [6:0]                bc_time,
   input  logic [3:0]                tdc_count,
   input  logic                      rdata,
   input  logic                      rstr,
   input  logic                      tdc_raw_lock,
   output logic [6+FINE_W:0]         tdc_raw,
   output logic [WIDTH_W+FINE_W-1:0] tdc_out,
   output logic                      tdc_rdy
);
   import tdcchan_pkg::*;

   logic               s;
   logic               rise;
   logic               fall;
   logic               report;
   logic               rstr_d;
   logic               rstr_edge;
   logic               accepted;
   logic [6:0]         prev_bc;
   logic [FINE_W-1:0]  fine;
   logic [FINE_W-1:0]  fine_stamp;
   logic [WIDTH_W-1:0] hit_width;
   tdc_raw_t           raw_q;
   tdc_out_t           out_q;

   tdcchan_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk600),
      .reset (reset),
      .pin   (pin_in),
      .s     (s),
      .rise  (rise),
      .fall  (fall)
   );

   assign pin_out   = s;
   assign rstr_edge = rstr & ~rstr_d;

`ifdef TDCCHAN_GLITCH_FILTER_EN
   assign report = fall & accepted & (hit_width >= WIDTH_W'(MIN_WIDTH));
`else
   logic unused_min_width;
   assign unused_min_width = (MIN_WIDTH > 0);
   assign report = fall & accepted;
`endif

   // Handshake: tdc_out is valid while tdc_rdy=1; a rising edge on rstr
   // acknowledges it, and a result landing in that same cycle wins.
   always_ff @(posedge clk600) begin
      if (reset) begin
         prev_bc    <= '0;
         fine       <= '0;
         fine_stamp <= '0;
         hit_width  <= '0;
         accepted   <= 1'b0;
         rstr_d     <= 1'b0;
         raw_q      <= '0;
         out_q      <= '0;
         tdc_rdy    <= 1'b0;
      end else begin
         prev_bc <= bc_time;
         rstr_d  <= rstr;
         if (bc_time != prev_bc) begin
            fine <= '0;
         end else if (fine != '1) begin
            fine <= fine + 1'b1;
         end
         if (rise) begin
            if (!tdc_raw_lock) begin
               raw_q <= '{bc: bc_time, fine: fine};
            end
            fine_stamp <= fine;
            accepted   <= rdata;
            hit_width  <= WIDTH_W'(1);
         end else if (s && hit_width != '1) begin
            hit_width <= hit_width + 1'b1;
         end
         if (report) begin
            out_q   <= '{width: hit_width,
                         fine:  fine_stamp - {{(FINE_W-4){1'b0}}, tdc_count}};
            tdc_rdy <= 1'b1;
         end else if (rstr_edge) begin
            tdc_rdy <= 1'b0;
         end
      end
   end

   assign tdc_raw = raw_q;
   assign tdc_out = out_q;

endmodule

// File: tb/tb_tdcchan.sv
// Bench for tdcchan: directed vector table, hand sequences, and random hits
// checked every cycle against a history-based reference model.
`timescale 1ns/1ps
module tb_tdcchan;

   localparam int SYNC  = 2;
   localparam int MIN_W = 2;

   logic        clk600;
   logic        reset;
   logic        pin_in;
   logic        pin_out;
   logic [6:0]  bc_time;
   logic [3:0]  tdc_count;
   logic        rdata;
   logic        rstr;
   logic        tdc_raw_lock;
   logic [12:0] tdc_raw;
   logic [11:0] tdc_out;
   logic        tdc_rdy;

   tdcchan #(.SYNC_STAGES(SYNC), .MIN_WIDTH(MIN_W)) dut (
      .clk600       (clk600),
      .reset        (reset),
      .pin_in       (pin_in),
      .pin_out      (pin_out),
      .bc_time      (bc_time),
      .tdc_count    (tdc_count),
      .rdata        (rdata),
      .rstr         (rstr),
      .tdc_raw_lock (tdc_raw_lock),
      .tdc_raw      (tdc_raw),
      .tdc_out      (tdc_out),
      .tdc_rdy      (tdc_rdy)
   );

   // clock / reset
   initial clk600 = 1'b0;
   always #0.833 clk600 = ~clk600;

   typedef struct {
      bit          ack;
      logic [6:0]  bc;
      int          age;
      int          hold;
      logic [3:0]  tc;
      bit          rd;
      bit          lk;
      logic [12:0] raw;
      logic [11:0] out;
      bit          rdy;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic        p_h[$];
   logic [6:0]  bc_h[$];
   logic        rd_h[$];
   logic        rs_h[$];
   logic        lk_h[$];
   logic [3:0]  tc_h[$];
   logic [11:0] exp_q[$];
   logic [12:0] exp_raw;
   logic [11:0] exp_out;
   logic        exp_rdy;
   logic [5:0]  m_stamp;
   logic        m_acc;
   int          m_rise;
   logic [6:0]  d_bc;
   logic        d_rd;
   logic        d_rs;
   logic        d_lk;
   logic [3:0]  d_tc;
   vec_t        vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, want);
      end
   endtask

   // synced level seen by the channel in cycle i (cycles counted from reset release)
   function automatic logic s_at(input int i);
      return (i >= SYNC) ? p_h[i-SYNC] : 1'b0;
   endfunction

   // fine time in cycle m: cycles bc_time has stayed unchanged, one-cycle lag, capped
   function automatic int fine_at(input int m);
      int n;
      logic [6:0] pb;
      n = 0;
      for (int k = m - 1; k >= 0 && n < 63; k--) begin
         pb = (k > 0) ? bc_h[k-1] : 7'd0;
         if (bc_h[k] != pb) break;
         n++;
      end
      return n;
   endfunction

   // scoreboard: applies cycle m's events, giving expectations for cycle m+1
   task automatic model(input int m);
      logic s_m, s_p, rs_prev, ok;
      int   f, w;
      s_m = s_at(m);
      s_p = s_at(m - 1);
      if (s_m && !s_p && m > SYNC) begin
         f = fine_at(m);
         if (!lk_h[m]) exp_raw = {bc_h[m], 6'(f)};
         m_stamp = 6'(f);
         m_acc   = rd_h[m];
         m_rise  = m;
      end
      ok = 1'b0;
      if (!s_m && s_p && m_acc) begin
         w = m - m_rise;
         if (w > 63) w = 63;
`ifdef TDCCHAN_GLITCH_FILTER_EN
         ok = (w >= MIN_W);
`else
         ok = 1'b1;
`endif
         if (ok) begin
            exp_out = {6'(w), 6'(m_stamp - {2'b00, tc_h[m]})};
            exp_q.push_back(exp_out);
         end
      end
      rs_prev = (m > 0) ? rs_h[m-1] : 1'b0;
      if (ok) exp_rdy = 1'b1;
      else if (rs_h[m] && !rs_prev) exp_rdy = 1'b0;
   endtask

   // driver: check current outputs, drive one cycle of inputs, advance
   task automatic step(input logic pin);
      chk("pin_out", 32'(pin_out), 32'(s_at(cyc)));
      chk("tdc_raw", 32'(tdc_raw), 32'(exp_raw));
      chk("tdc_out", 32'(tdc_out), 32'(exp_out));
      chk("tdc_rdy", 32'(tdc_rdy), 32'(exp_rdy));
      while (exp_q.size() > 0) chk("report", 32'(tdc_out), 32'(exp_q.pop_front()));
      pin_in = pin; bc_time = d_bc; rdata = d_rd; rstr = d_rs;
      tdc_raw_lock = d_lk; tdc_count = d_tc;
      p_h.push_back(pin); bc_h.push_back(d_bc); rd_h.push_back(d_rd);
      rs_h.push_back(d_rs); lk_h.push_back(d_lk); tc_h.push_back(d_tc);
      model(cyc);
      cyc++;
      @(posedge clk600); #0.2;
   endtask

   task automatic do_reset(input logic pin, input int n);
      reset = 1'b1;
      pin_in = pin;
      repeat (n) begin
         @(posedge clk600); #0.2;
         chk("rst_pin_out", 32'(pin_out), 32'd0);
         chk("rst_tdc_raw", 32'(tdc_raw), 32'd0);
         chk("rst_tdc_out", 32'(tdc_out), 32'd0);
         chk("rst_tdc_rdy", 32'(tdc_rdy), 32'd0);
      end
      reset = 1'b0;
      cyc = 0;
      p_h.delete(); bc_h.delete(); rd_h.delete(); rs_h.delete(); lk_h.delete(); tc_h.delete();
      exp_q.delete();
      exp_raw = '0; exp_out = '0; exp_rdy = 1'b0;
      m_stamp = '0; m_acc = 1'b0; m_rise = 0;
   endtask

   // one hit whose rise sees fine == age (capped) under bc_time == v.bc
   task automatic run_vec(input vec_t v, input int idx);
      if (v.ack) begin
         d_rs = 1'b1; step(1'b0);
         d_rs = 1'b0; step(1'b0);
      end
      d_rd = v.rd; d_lk = v.lk; d_tc = v.tc;
      d_bc = v.bc ^ 7'h1; step(1'b0);
      d_bc = v.bc;        step(1'b0);
      repeat (v.age - 2) step(1'b0);
      repeat (v.hold) step(1'b1);
      repeat (6) step(1'b0);
      chk($sformatf("vec%0d_raw", idx), 32'(tdc_raw), 32'(v.raw));
      chk($sformatf("vec%0d_out", idx), 32'(tdc_out), 32'(v.out));
      chk($sformatf("vec%0d_rdy", idx), 32'(tdc_rdy), 32'(v.rdy));
   endtask

   initial begin
      int   run_left;
      int   bc_cnt;
      logic pv;

      reset = 1'b1; pin_in = 1'b0; bc_time = '0; tdc_count = '0;
      rdata = 1'b0; rstr = 1'b0; tdc_raw_lock = 1'b0;
      d_bc = '0; d_rd = 1'b1; d_rs = 1'b0; d_lk = 1'b0; d_tc = '0;

      //           ack  bc     age hold tc    rd lk  raw       out       rdy
      vecs[0] = '{1'b0, 7'd5,  7,  10,  4'd0, 1, 0, 13'h147, 12'h287, 1'b1};
      vecs[1] = '{1'b0, 7'd5,  7,  10,  4'd9, 1, 0, 13'h147, 12'h2BE, 1'b1};
      vecs[2] = '{1'b1, 7'd6,  3,  5,   4'd0, 1, 1, 13'h147, 12'h143, 1'b1};
      vecs[3] = '{1'b1, 7'd10, 70, 80,  4'd0, 1, 0, 13'h2BF, 12'hFFF, 1'b1};
      vecs[4] = '{1'b1, 7'd20, 4,  6,   4'd0, 0, 0, 13'h504, 12'hFFF, 1'b0};
`ifdef TDCCHAN_GLITCH_FILTER_EN
      vecs[5] = '{1'b1, 7'd30, 5,  1,   4'd2, 1, 0, 13'h785, 12'hFFF, 1'b0};
`else
      vecs[5] = '{1'b1, 7'd30, 5,  1,   4'd2, 1, 0, 13'h785, 12'h043, 1'b1};
`endif
      vecs[6] = '{1'b1, 7'd31, 5,  2,   4'd0, 1, 0, 13'h7C5, 12'h085, 1'b1};
      vecs[7] = '{1'b0, 7'd3,  6,  5,   4'd0, 1, 0, 13'h0C6, 12'h146, 1'b1};

      do_reset(1'b0, 4);
      repeat (8) step(1'b0);

      run_vec(vecs[0], 0);
      run_vec(vecs[1], 1);
      // acknowledge clears tdc_rdy one cycle later; the result stays
      d_rs = 1'b1; step(1'b0);
      chk("ack_rdy", 32'(tdc_rdy), 32'd0);
      chk("ack_out_hold", 32'(tdc_out), 32'h2BE);
      d_rs = 1'b0; step(1'b0);
      for (int i = 2; i < 7; i++) run_vec(vecs[i], i);

      // acknowledge edge on the very cycle a new result lands
      repeat (4) step(1'b1);
      repeat (2) step(1'b0);
      d_rs = 1'b1; step(1'b0);
      chk("race_rdy", 32'(tdc_rdy), 32'd1);
      chk("race_width", 32'(tdc_out[11:6]), 32'd4);
      d_rs = 1'b0; step(1'b0);
      chk("race_rdy_hold", 32'(tdc_rdy), 32'd1);

      // reset in the middle of a hit, pin still high afterwards
      repeat (5) step(1'b1);
      do_reset(1'b1, 3);
      repeat (10) step(1'b1);
      chk("rst_hit_raw", 32'(tdc_raw), 32'd0);
      repeat (6) step(1'b0);
      chk("rst_hit_rdy", 32'(tdc_rdy), 32'd0);
      chk("rst_hit_out", 32'(tdc_out), 32'd0);
      run_vec(vecs[7], 7);

      // randomized traffic
      d_lk = 1'b0; d_rd = 1'b1; d_rs = 1'b0;
      run_left = 20; pv = 1'b0; bc_cnt = 14;
      repeat (3000) begin
         if (run_left == 0) begin
            pv = ~pv;
            run_left = pv ? $urandom_range(1, 90) : $urandom_range(1, 40);
         end
         run_left--;
         if (bc_cnt == 0) begin
            d_bc++;
            bc_cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 90) : 14;
         end else begin
            bc_cnt--;
         end
         if ($urandom_range(0, 19) == 0) d_rd = ~d_rd;
         if ($urandom_range(0, 7) == 0)  d_rs = ~d_rs;
         if ($urandom_range(0, 49) == 0) d_lk = ~d_lk;
         if ($urandom_range(0, 29) == 0) d_tc = 4'($urandom_range(0, 15));
         step(pv);
      end
      repeat (8) step(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
